// File: rtl/lcd_nibble_driver.sv
// HD44780 4-bit write driver: one byte in over VALID/READY, two E-strobed nibbles out on SF_D.
// Latency: READY returns 2*(T_SU+T_EW+T_H)+T_NIB+gap cycles after accept (gap = T_CLR for clear/home, else T_BYTE).
// Backpressure: READY only in IDLE, no queue, VALID is ignored while busy. `LCD_INIT_SEQ_EN adds the power-up init sequence.
module lcd_nibble_driver #(
  parameter int T_SU   = 2,
  parameter int T_EW   = 12,
  parameter int T_H    = 1,
  parameter int T_NIB  = 50,
  parameter int T_BYTE = 2000,
  parameter int T_CLR  = 82000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] DIN,
  input  logic       RS_IN,
  input  logic       VALID,
  output logic       READY,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic [3:0] SF_D
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_SU_H     = 4'd1;
  localparam logic [3:0] S_EH_H     = 4'd2;
  localparam logic [3:0] S_HD_H     = 4'd3;
  localparam logic [3:0] S_GAP_N    = 4'd4;
  localparam logic [3:0] S_SU_L     = 4'd5;
  localparam logic [3:0] S_EH_L     = 4'd6;
  localparam logic [3:0] S_HD_L     = 4'd7;
  localparam logic [3:0] S_GAP_B    = 4'd8;
`ifdef LCD_INIT_SEQ_EN
  localparam logic [3:0] S_INIT_WAIT = 4'd9;
  localparam logic [3:0] S_INIT_SU   = 4'd10;
  localparam logic [3:0] S_INIT_EH   = 4'd11;
  localparam logic [3:0] S_INIT_HD   = 4'd12;
  localparam logic [3:0] S_INIT_GAP  = 4'd13;
`endif

  // Counter reload values are (length - 1): the state exits when the count hits zero.
  localparam logic [19:0] L_SU   = 20'(T_SU - 1);
  localparam logic [19:0] L_EW   = 20'(T_EW - 1);
  localparam logic [19:0] L_H    = 20'(T_H - 1);
  localparam logic [19:0] L_NIB  = 20'(T_NIB - 1);
  localparam logic [19:0] L_BYTE = 20'(T_BYTE - 1);
  localparam logic [19:0] L_CLR  = 20'(T_CLR - 1);
`ifdef LCD_INIT_SEQ_EN
  localparam logic [19:0] L_PWR  = 20'(750000 - 1);
  localparam logic [19:0] L_I0   = 20'(205000 - 1);
  localparam logic [19:0] L_I1   = 20'(5000 - 1);
  localparam logic [19:0] L_I23  = 20'(2000 - 1);
`endif

  logic [3:0]  r_state;
  logic [19:0] r_cnt;
  logic [3:0]  r_lo;
  logic        r_clr;
  logic        r_e;
  logic        r_rs;
  logic [3:0]  r_sfd;
`ifdef LCD_INIT_SEQ_EN
  logic [1:0]  r_init_idx;
  logic [19:0] w_init_gap;
`endif

  logic        w_adv;
  logic [3:0]  w_nxt_state;
  logic [19:0] w_nxt_len;
  logic        w_nxt_e;

`ifdef LCD_INIT_SEQ_EN
  always_comb begin
    w_init_gap = L_I23;
    case (r_init_idx)
      2'd0:    w_init_gap = L_I0;
      2'd1:    w_init_gap = L_I1;
      default: w_init_gap = L_I23;
    endcase
  end
`endif

  always_comb begin
    w_adv       = (r_state == S_IDLE) ? VALID : (r_cnt == '0);
    w_nxt_state = S_IDLE;
    w_nxt_len   = '0;
    w_nxt_e     = 1'b0;
    case (r_state)
      S_IDLE:  begin w_nxt_state = S_SU_H;  w_nxt_len = L_SU;  end
      S_SU_H:  begin w_nxt_state = S_EH_H;  w_nxt_len = L_EW;  w_nxt_e = 1'b1; end
      S_EH_H:  begin w_nxt_state = S_HD_H;  w_nxt_len = L_H;   end
      S_HD_H:  begin w_nxt_state = S_GAP_N; w_nxt_len = L_NIB; end
      S_GAP_N: begin w_nxt_state = S_SU_L;  w_nxt_len = L_SU;  end
      S_SU_L:  begin w_nxt_state = S_EH_L;  w_nxt_len = L_EW;  w_nxt_e = 1'b1; end
      S_EH_L:  begin w_nxt_state = S_HD_L;  w_nxt_len = L_H;   end
      S_HD_L:  begin w_nxt_state = S_GAP_B; w_nxt_len = r_clr ? L_CLR : L_BYTE; end
      S_GAP_B: begin w_nxt_state = S_IDLE;  w_nxt_len = '0;    end
`ifdef LCD_INIT_SEQ_EN
      S_INIT_WAIT: begin w_nxt_state = S_INIT_SU;  w_nxt_len = L_SU; end
      S_INIT_SU:   begin w_nxt_state = S_INIT_EH;  w_nxt_len = L_EW; w_nxt_e = 1'b1; end
      S_INIT_EH:   begin w_nxt_state = S_INIT_HD;  w_nxt_len = L_H;  end
      S_INIT_HD:   begin w_nxt_state = S_INIT_GAP; w_nxt_len = w_init_gap; end
      S_INIT_GAP: begin
        if (r_init_idx == 2'd3) begin
          w_nxt_state = S_IDLE;
          w_nxt_len   = '0;
        end else begin
          w_nxt_state = S_INIT_SU;
          w_nxt_len   = L_SU;
        end
      end
`endif
      default: begin w_nxt_state = S_IDLE; w_nxt_len = '0; end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
`ifdef LCD_INIT_SEQ_EN
      r_state    <= S_INIT_WAIT;
      r_cnt      <= L_PWR;
      r_init_idx <= 2'd0;
`else
      r_state    <= S_IDLE;
      r_cnt      <= '0;
`endif
      r_lo       <= '0;
      r_clr      <= 1'b0;
      r_e        <= 1'b0;
      r_rs       <= 1'b0;
      r_sfd      <= '0;
    end else if (w_adv) begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_len;
      r_e     <= w_nxt_e;
      if (r_state == S_IDLE) begin
        r_sfd <= DIN[7:4];
        r_rs  <= RS_IN;
        r_lo  <= DIN[3:0];
        // Clear display (0x01) and return home (0x02/0x03) need the long settle time.
        r_clr <= !RS_IN && (DIN[7:2] == 6'd0) && (DIN[1:0] != 2'd0);
      end
      if (r_state == S_GAP_N)
        r_sfd <= r_lo;
`ifdef LCD_INIT_SEQ_EN
      if (r_state == S_INIT_WAIT) begin
        r_sfd <= 4'h3;
        r_rs  <= 1'b0;
      end
      if (r_state == S_INIT_GAP) begin
        r_sfd      <= (r_init_idx == 2'd2) ? 4'h2 : 4'h3;
        r_init_idx <= r_init_idx + 2'd1;
      end
`endif
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 20'd1;
    end
  end

  assign READY  = (r_state == S_IDLE);
  assign LCD_E  = r_e;
  assign LCD_RS = r_rs;
  assign LCD_RW = 1'b0;
  assign SF_D   = r_sfd;

endmodule

// File: tb/tb_lcd_nibble_driver.sv
// Directed bench for lcd_nibble_driver (default build): nibble timing, gap lengths, busy hold-off, async reset.
module tb_lcd_nibble_driver;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] DIN;
  logic       RS_IN;
  logic       VALID;
  logic       READY;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_E;
  logic [3:0] SF_D;

  int vectors = 0;
  int miscompares = 0;

  lcd_nibble_driver dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .DIN    (DIN),
    .RS_IN  (RS_IN),
    .VALID  (VALID),
    .READY  (READY),
    .LCD_RS (LCD_RS),
    .LCD_RW (LCD_RW),
    .LCD_E  (LCD_E),
    .SF_D   (SF_D)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; accepts one byte and follows it sample by sample until READY returns.
  // Sample n is taken at the negedge after rising edge n (edge 0 = accept edge).
  task automatic run_byte(input logic [7:0] din, input logic rs, input bit hold,
                          input logic [3:0] exp_hi, input logic [3:0] exp_lo,
                          input int exp_ready, input string tag);
    int rise1 = -1, rise2 = -1, w1 = 0, w2 = 0, pulses = 0, ready_at = -1;
    logic [3:0] nib1 = 'x, nib2 = 'x;
    logic prev_e = 1'b0;
    bit unstable = 0, rs_bad = 0;
    DIN = din; RS_IN = rs; VALID = 1'b1;
    @(posedge CLK);
    for (int n = 0; n <= exp_ready + 20; n++) begin
      @(negedge CLK);
      if (n == 0) begin
        check({tag, "_sfd_hi_first"}, SF_D, exp_hi);
        check({tag, "_rs_first"}, LCD_RS, rs);
        check({tag, "_ready_low"}, READY, 1'b0);
        check({tag, "_e_low_first"}, LCD_E, 1'b0);
        if (!hold) VALID = 1'b0;
      end
      if (LCD_E && !prev_e) begin
        pulses++;
        if (pulses == 1) begin rise1 = n; nib1 = SF_D; end
        else if (pulses == 2) begin rise2 = n; nib2 = SF_D; end
      end
      if (LCD_E) begin
        if (pulses == 1) begin w1++; if (SF_D !== nib1) unstable = 1; end
        else begin w2++; if (SF_D !== nib2) unstable = 1; end
        if (LCD_RS !== rs) rs_bad = 1;
      end
      prev_e = LCD_E;
      if (READY) begin
        ready_at = n;
        break;
      end
      if (hold) begin
        DIN = 8'($urandom);
        RS_IN = 1'($urandom);
      end
    end
    check({tag, "_pulses"}, pulses, 2);
    check({tag, "_rise1"}, rise1, 2);
    check({tag, "_width1"}, w1, 12);
    check({tag, "_nib_hi"}, nib1, exp_hi);
    check({tag, "_rise2"}, rise2, 67);
    check({tag, "_width2"}, w2, 12);
    check({tag, "_nib_lo"}, nib2, exp_lo);
    check({tag, "_e_stable"}, {31'd0, unstable}, 0);
    check({tag, "_rs_in_pulse"}, {31'd0, rs_bad}, 0);
    check({tag, "_ready_at"}, ready_at, exp_ready);
  endtask

  initial begin
    RST_N = 1'b0; VALID = 1'b0; DIN = 8'h00; RS_IN = 1'b0;
    #1;
    check("rst_e", LCD_E, 1'b0);
    check("rst_ready", READY, 1'b1);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("init_ready", READY, 1'b1);
    check("init_e", LCD_E, 1'b0);
    check("init_sfd", SF_D, 4'h0);
    check("init_rw", LCD_RW, 1'b0);
    check("init_rs", LCD_RS, 1'b0);
    repeat (3) @(negedge CLK);
    check("idle_no_start", READY, 1'b1);

    run_byte(8'h48, 1'b1, 1'b0, 4'h4, 4'h8, 2080, "data48");
    check("data48_rw", LCD_RW, 1'b0);
    check("data48_sfd_hold", SF_D, 4'h8);

    run_byte(8'h01, 1'b0, 1'b0, 4'h0, 4'h1, 82080, "clear01");
    run_byte(8'h04, 1'b0, 1'b1, 4'h0, 4'h4, 2080, "cmd04_busy");

    // VALID still high: the next byte must be taken on the first edge with READY=1.
    DIN = 8'h48; RS_IN = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("b2b_ready_low", READY, 1'b0);
    check("b2b_sfd", SF_D, 4'h4);
    check("b2b_rs", LCD_RS, 1'b1);
    VALID = 1'b0;
    repeat (70) @(negedge CLK);
    check("midrst_e_high", LCD_E, 1'b1);
    check("midrst_sfd_lo", SF_D, 4'h8);
    #2 RST_N = 1'b0;
    #1;
    check("midrst_e_async", LCD_E, 1'b0);
    check("midrst_ready", READY, 1'b1);
    @(negedge CLK);
    RST_N = 1'b1;
    begin
      int e_seen = 0, ready_drop = 0;
      for (int n = 0; n < 200; n++) begin
        @(negedge CLK);
        if (LCD_E) e_seen++;
        if (!READY) ready_drop++;
      end
      check("post_rst_no_pulse", e_seen, 0);
      check("post_rst_ready", ready_drop, 0);
    end
    check("post_rst_sfd", SF_D, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
